// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared state encoding and datapath widths for the forward sequencer
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    LOSS = 2'd2,
    DONE = 2'd3
  } neuron_state_t;

  localparam int X_W   = 10;
  localparam int W_W   = 8;
  localparam int ACC_W = 21;
  localparam int TGT_W = 4;
  localparam int PROD_W = X_W + W_W;

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

endpackage

// File: rtl/neuron_fwd_sequencer_if.sv
// rtl/neuron_fwd_sequencer_if.sv - operand fetch, loss handshake and status bus of the sequencer
interface neuron_fwd_sequencer_if
  import neuron_pkg::*;
#(
  parameter int IDX_W = 4
);
  logic             start_i;
  logic [TGT_W-1:0] target_i;
  logic [IDX_W-1:0] idx_o;
  logic [X_W-1:0]   x_i;
  logic [W_W-1:0]   w_i;
  logic             loss_req_o;
  logic             loss_ack_i;
  logic [ACC_W-1:0] acc_o;
  logic [TGT_W-1:0] target_o;
  logic             busy_o;
  logic             done_o;
  logic             ovf_o;

  modport master (
    input  start_i, target_i, x_i, w_i, loss_ack_i,
    output idx_o, loss_req_o, acc_o, target_o, busy_o, done_o, ovf_o
  );

  modport slave (
    output start_i, target_i, x_i, w_i, loss_ack_i,
    input  idx_o, loss_req_o, acc_o, target_o, busy_o, done_o, ovf_o
  );
endinterface

// File: rtl/neuron_mac_unit.sv
// rtl/neuron_mac_unit.sv - combinational unsigned multiply-add saturating at ACC_MAX
module neuron_mac_unit
  import neuron_pkg::*;
(
  input  logic [ACC_W-1:0] i_acc,
  input  logic [X_W-1:0]   i_x,
  input  logic [W_W-1:0]   i_w,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_sat
);
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W:0]    w_wide;

  assign w_prod = {{W_W{1'b0}}, i_x} * {{X_W{1'b0}}, i_w};
  // One guard bit is enough: ACC_MAX plus an 18-bit product never exceeds 2^(ACC_W+1)-1
  assign w_wide = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, w_prod};
  assign o_sat  = (w_wide > {1'b0, ACC_MAX});
  assign o_sum  = o_sat ? ACC_MAX : w_wide[ACC_W-1:0];
endmodule

// File: rtl/neuron_fwd_sequencer.sv
// rtl/neuron_fwd_sequencer.sv - steps one MAC over NUM_INPUTS operand pairs, hands the sum to loss_calc
module neuron_fwd_sequencer
  import neuron_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int IDX_W      = 4
)(
  input logic                   clk_i,
  input logic                   rst_i,
  neuron_fwd_sequencer_if.master bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  neuron_state_t    r_state;
  logic [IDX_W-1:0] r_idx;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_acc_o;
  logic [TGT_W-1:0] r_target;
  logic             r_loss_req;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic [ACC_W-1:0] w_sum;
  logic             w_sat;

  neuron_mac_unit u_mac (
    .i_acc (r_acc),
    .i_x   (bus.x_i),
    .i_w   (bus.w_i),
    .o_sum (w_sum),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_acc      <= '0;
      r_acc_o    <= '0;
      r_target   <= '0;
      r_loss_req <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start_i) begin
            r_acc    <= '0;
            r_idx    <= '0;
            r_ovf    <= 1'b0;
            r_target <= bus.target_i;
            r_busy   <= 1'b1;
            r_state  <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_sum;
          if (w_sat) r_ovf <= 1'b1;
          // idx parks on the last pair so the loss side sees a stable index
          if (r_idx == LAST_IDX) begin
            r_acc_o    <= w_sum;
            r_loss_req <= 1'b1;
            r_state    <= LOSS;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        LOSS: begin
          if (bus.loss_ack_i) begin
            r_loss_req <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.idx_o      = r_idx;
  assign bus.acc_o      = r_acc_o;
  assign bus.target_o   = r_target;
  assign bus.loss_req_o = r_loss_req;
  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
  assign bus.ovf_o      = r_ovf;
endmodule

// File: tb/tb_neuron_fwd_sequencer.sv
// tb/tb_neuron_fwd_sequencer.sv - directed self-checking bench for neuron_fwd_sequencer
module tb_neuron_fwd_sequencer;
  import neuron_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  int   cyc;
  int   d0;

  logic [X_W-1:0] x_mem [16];
  logic [W_W-1:0] w_mem [16];

  always #5 clk = ~clk;

  neuron_fwd_sequencer_if #(.IDX_W(4)) bus ();

  neuron_fwd_sequencer #(.NUM_INPUTS(16), .IDX_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  assign bus.x_i = x_mem[bus.idx_o];
  assign bus.w_i = w_mem[bus.idx_o];

  always @(negedge clk) if (bus.done_o) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0: begin x_mem[i] = 10'd1;    w_mem[i] = 8'd1;   end
        1: begin x_mem[i] = 10'(i);   w_mem[i] = 8'd2;   end
        default: begin x_mem[i] = 10'd1023; w_mem[i] = 8'd255; end
      endcase
    end
  endtask

  task automatic start_pass(input logic [3:0] tgt);
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.target_i = tgt;
    @(negedge clk);
    bus.start_i  = 1'b0;
    bus.target_i = 4'h0;
  endtask

  task automatic wait_req(output int cycles);
    cycles = 0;
    while (!bus.loss_req_o && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (int'(bus.idx_o) != idx && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_idx_timeout", (n < 100), 1);
  endtask

  task automatic do_ack();
    bus.loss_ack_i = 1'b1;
    @(negedge clk);
    bus.loss_ack_i = 1'b0;
    check("ack_done_hi", bus.done_o, 1);
    check("ack_req_lo", bus.loss_req_o, 0);
    @(negedge clk);
    check("post_done_lo", bus.done_o, 0);
    check("post_busy_lo", bus.busy_o, 0);
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.target_i   = 4'h0;
    bus.loss_ack_i = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_idx", bus.idx_o, 0);
    check("rst_acc", bus.acc_o, 0);
    check("rst_tgt", bus.target_o, 0);
    check("rst_req", bus.loss_req_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_ovf", bus.ovf_o, 0);

    // ack outside LOSS must be ignored
    bus.loss_ack_i = 1'b1;
    @(negedge clk);
    bus.loss_ack_i = 1'b0;
    check("idle_ack_done", bus.done_o, 0);

    // basic sum
    start_pass(4'h5);
    check("basic_busy", bus.busy_o, 1);
    wait_req(cyc);
    check("basic_lat", cyc, 16);
    check("basic_acc", bus.acc_o, 16);
    check("basic_tgt", bus.target_o, 5);
    check("basic_ovf", bus.ovf_o, 0);
    check("basic_idx", bus.idx_o, 15);
    do_ack();

    // indexed operands plus delayed ack
    fill(1);
    start_pass(4'h3);
    for (int i = 0; i < 16; i++) begin
      check("idx_step", bus.idx_o, i);
      @(negedge clk);
    end
    check("idx_req", bus.loss_req_o, 1);
    check("idx_acc", bus.acc_o, 240);
    d0 = done_cnt;
    for (int k = 0; k < 5; k++) begin
      check("hold_req", bus.loss_req_o, 1);
      check("hold_acc", bus.acc_o, 240);
      check("hold_tgt", bus.target_o, 3);
      check("hold_done", bus.done_o, 0);
      @(negedge clk);
    end
    do_ack();
    repeat (2) @(negedge clk);
    check("hold_one_done", done_cnt - d0, 1);

    // saturation boundary: 8 pairs fit, the 9th clips
    fill(2);
    start_pass(4'h9);
    wait_idx(8);
    check("sat_ovf_8", bus.ovf_o, 0);
    @(negedge clk);
    check("sat_ovf_9", bus.ovf_o, 1);
    wait_req(cyc);
    check("sat_acc", bus.acc_o, 2097151);
    check("sat_ovf", bus.ovf_o, 1);
    do_ack();
    check("sat_ovf_idle", bus.ovf_o, 1);
    check("sat_acc_idle", bus.acc_o, 2097151);
    fill(0);
    start_pass(4'h0);
    check("ovf_clr", bus.ovf_o, 0);
    wait_req(cyc);
    check("clr_acc", bus.acc_o, 16);
    do_ack();

    // start while busy: mid-MAC, LOSS and DONE cycle
    fill(1);
    start_pass(4'h7);
    repeat (5) @(negedge clk);
    bus.start_i  = 1'b1;
    bus.target_i = 4'h2;
    @(negedge clk);
    bus.start_i  = 1'b0;
    wait_req(cyc);
    check("busy_lat", cyc, 10);
    check("busy_acc", bus.acc_o, 240);
    check("busy_tgt", bus.target_o, 7);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("busy_loss_req", bus.loss_req_o, 1);
    d0 = done_cnt;
    bus.loss_ack_i = 1'b1;
    @(negedge clk);
    bus.loss_ack_i = 1'b0;
    check("busy_done", bus.done_o, 1);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("busy_idle", bus.busy_o, 0);
    @(negedge clk);
    check("busy_still_idle", bus.busy_o, 0);
    @(negedge clk);
    check("busy_one_done", done_cnt - d0, 1);
    check("busy_tgt_kept", bus.target_o, 7);

    // reset mid-pass
    fill(0);
    start_pass(4'h1);
    wait_idx(7);
    #2 rst = 1'b1;
    #1;
    check("mrst_idx", bus.idx_o, 0);
    check("mrst_acc", bus.acc_o, 0);
    check("mrst_tgt", bus.target_o, 0);
    check("mrst_req", bus.loss_req_o, 0);
    check("mrst_busy", bus.busy_o, 0);
    check("mrst_done", bus.done_o, 0);
    @(negedge clk);
    rst = 1'b0;
    start_pass(4'h6);
    wait_req(cyc);
    check("mrst_lat", cyc, 16);
    check("mrst_acc2", bus.acc_o, 16);
    check("mrst_tgt2", bus.target_o, 6);
    do_ack();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
